// File: rtl/z80_bus_arbiter_if.sv
// Bus bundle between a DMA requester, a Z80 CPU and a single-port synchronous memory.
// The arbiter connects through the slave modport; the environment uses master.
interface z80_bus_arbiter_if;
    // DMA requester side
    logic        dma_req;
    logic        dma_we;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_ack;
    logic [7:0]  dma_rdata;

    // Z80 CPU side
    logic        cpu_busrq_n;
    logic        cpu_busak_n;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_do;
    logic        cpu_mreq_n;
    logic        cpu_wr_n;
    logic [7:0]  cpu_di;

    // Memory port
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;

    // Status
    logic        dma_owner;
    logic        arb_err;

    modport slave (
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_ack, dma_rdata,
        output cpu_busrq_n,
        input  cpu_busak_n, cpu_a, cpu_do, cpu_mreq_n, cpu_wr_n,
        output cpu_di,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata,
        output dma_owner, arb_err
    );

    modport master (
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_ack, dma_rdata,
        input  cpu_busrq_n,
        output cpu_busak_n, cpu_a, cpu_do, cpu_mreq_n, cpu_wr_n,
        input  cpu_di,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata,
        input  dma_owner, arb_err
    );
endinterface

// File: rtl/z80_bus_arbiter.sv
// DMA / Z80 bus arbiter: takes the bus via BUSRQ/BUSAK, runs bounded DMA bursts, then returns it.
// Optional busak_n wait timeout enabled by defining ARB_TIMEOUT_EN.
module z80_bus_arbiter #(
    parameter int MAX_BURST      = 16,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               reset_n,
    z80_bus_arbiter_if.slave   bus
);

    localparam int BW = ($clog2(MAX_BURST + 1) > 5) ? $clog2(MAX_BURST + 1) : 5;
    localparam int GAP_N = (GAP_CYCLES > 1) ? GAP_CYCLES : 1;
    localparam int GW = (GAP_N > 1) ? $clog2(GAP_N) : 1;
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_N - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        GRANT,
        ACCESS,
        RELEASE,
        GAP
    } state_t;

    state_t      state, state_nx;
    logic [BW-1:0] burst_cnt, burst_cnt_nx;
    logic [GW-1:0] gap_cnt, gap_cnt_nx;
    logic [15:0] lat_addr;
    logic [7:0]  lat_wdata;
    logic        lat_we;
    logic        latch_en;
    logic        ack_q, ack_nx;
    logic        timeout;

`ifdef ARB_TIMEOUT_EN
    localparam int TIMEOUT_N = (TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES : 1;
    localparam int TW = $clog2(TIMEOUT_N + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_N - 1);

    logic [TW-1:0] to_cnt, to_cnt_nx;

    always_comb begin
        to_cnt_nx = (state == REQ) ? to_cnt + TW'(1) : '0;
        timeout   = (state == REQ) && bus.cpu_busak_n && (to_cnt == TIMEOUT_LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt_nx;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nx     = state;
        burst_cnt_nx = burst_cnt;
        gap_cnt_nx   = gap_cnt;
        latch_en     = 1'b0;
        ack_nx       = 1'b0;

        case (state)
            IDLE: begin
                if (bus.dma_req) begin
                    state_nx = REQ;
                end
            end

            REQ: begin
                if (!bus.cpu_busak_n) begin
                    state_nx = GRANT;
                end else if (timeout) begin
                    state_nx = GAP;
                end
            end

            GRANT: begin
                // The ack cycle still shows the completed request, so it is never re-accepted.
                if (bus.cpu_busak_n) begin
                    state_nx = RELEASE;
                end else if ((burst_cnt == BURST_MAX) || !bus.dma_req) begin
                    state_nx = RELEASE;
                end else if (!ack_q) begin
                    latch_en = 1'b1;
                    if (burst_cnt < BURST_MAX) begin
                        burst_cnt_nx = burst_cnt + BW'(1);
                    end
                    state_nx = ACCESS;
                end
            end

            ACCESS: begin
                // An access in flight always completes, even if the CPU grabs the bus back.
                ack_nx   = 1'b1;
                state_nx = bus.cpu_busak_n ? RELEASE : GRANT;
            end

            RELEASE: begin
                if (bus.cpu_busak_n) begin
                    state_nx     = GAP;
                    burst_cnt_nx = '0;
                end
            end

            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nx   = IDLE;
                    gap_cnt_nx = '0;
                end else begin
                    gap_cnt_nx = gap_cnt + GW'(1);
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            burst_cnt <= '0;
            gap_cnt   <= '0;
            ack_q     <= 1'b0;
        end else begin
            state     <= state_nx;
            burst_cnt <= burst_cnt_nx;
            gap_cnt   <= gap_cnt_nx;
            ack_q     <= ack_nx;
        end
    end

    // NOTE: the request latches are reset as well, so the memory port never carries X after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
        end else if (latch_en) begin
            lat_addr  <= bus.dma_addr;
            lat_wdata <= bus.dma_wdata;
            lat_we    <= bus.dma_we;
        end
    end

    logic owner;
    logic cpu_we;

    assign owner  = (state == GRANT) || (state == ACCESS);
    assign cpu_we = !bus.cpu_mreq_n && !bus.cpu_wr_n;

    assign bus.dma_owner   = owner;
    assign bus.cpu_busrq_n = !((state == REQ) || (state == GRANT) || (state == ACCESS));
    assign bus.mem_addr    = owner ? lat_addr  : bus.cpu_a;
    assign bus.mem_wdata   = owner ? lat_wdata : bus.cpu_do;
    // Gating with reset_n keeps the write strobe low for the whole reset, whatever the CPU drives.
    assign bus.mem_we      = reset_n && (owner ? ((state == ACCESS) && lat_we) : cpu_we);
    assign bus.cpu_di      = bus.mem_rdata;
    assign bus.dma_ack     = ack_q;
    assign bus.dma_rdata   = ack_q ? bus.mem_rdata : 8'h00;
    assign bus.arb_err     = timeout;

endmodule

// File: doc/z80_bus_arbiter.md
Z80_BUS_ARBITER -- requirements
Module: z80_bus_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 16: maximum DMA accesses per bus tenure.
REQ-002 SHALL have parameter GAP_CYCLES, default 4: minimum cycles the CPU owns the bus between DMA tenures.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255: busak_n wait limit; used only with ARB_TIMEOUT_EN.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port dma_req  in  1  DMA access request; held until dma_ack.
REQ-007 SHALL have port dma_we  in  1  1 = write, 0 = read; qualified by dma_req.
REQ-008 SHALL have port dma_addr  in  16  DMA address.
REQ-009 SHALL have port dma_wdata  in  8  DMA write data.
REQ-010 SHALL have port dma_ack  out  1  one-cycle completion pulse.
REQ-011 SHALL have port dma_rdata  out  8  read data; valid when dma_ack=1.
REQ-012 SHALL have port cpu_busrq_n  out  1  to CPU busrq_n.
REQ-013 SHALL have port cpu_busak_n  in  1  from CPU busak_n.
REQ-014 SHALL have ports cpu_a in 16, cpu_do in 8, cpu_mreq_n in 1, cpu_wr_n in 1: CPU bus.
REQ-015 SHALL have port cpu_di  out  8  CPU read data.
REQ-016 SHALL have ports mem_addr out 16, mem_wdata out 8, mem_we out 1, mem_rdata in 8: single-port memory, synchronous read, 1-cycle latency.
REQ-017 SHALL have port dma_owner  out  1  1 while DMA owns the memory port.
REQ-018 SHALL have port arb_err  out  1  one-cycle pulse on busak_n timeout.

Function
REQ-019 SHALL implement states IDLE, REQ, GRANT, ACCESS, RELEASE, GAP.
REQ-020 IDLE: cpu_busrq_n=1; dma_req=1 -> REQ next cycle.
REQ-021 REQ: cpu_busrq_n=0; cpu_busak_n sampled 0 -> GRANT.
REQ-022 GRANT: dma_owner=1; dma_req=1 -> latch addr/wdata/we, increment burst count, -> ACCESS; dma_req=0 or burst count = MAX_BURST -> RELEASE.
REQ-023 ACCESS: memory driven from latched values for exactly one cycle; next cycle dma_ack=1, dma_rdata=mem_rdata, -> GRANT; request-to-ack latency = 2 cycles after the GRANT accept edge.
REQ-024 RELEASE: cpu_busrq_n=1, dma_owner=0; cpu_busak_n sampled 1 -> GAP, burst count cleared.
REQ-025 GAP: counts GAP_CYCLES cycles, then -> IDLE; dma_req during GAP is held off, never dropped.
REQ-026 dma_owner=0: mem_addr=cpu_a, mem_wdata=cpu_do, mem_we=!cpu_mreq_n & !cpu_wr_n.
REQ-027 dma_owner=1: mem_we driven only in ACCESS for writes; CPU strobes ignored.
REQ-028 cpu_di=mem_rdata at all times.
REQ-029 dma_req dropped before ack in GRANT: no access; -> RELEASE.
REQ-030 cpu_busak_n rising while owner (protocol error): -> RELEASE immediately; an access in flight completes and is acked.
REQ-031 Burst counter 5 bits minimum, saturates at MAX_BURST, no wrap-around.

Reset
REQ-032 reset_n=0 SHALL asynchronously force state=IDLE, counters=0, latches=0.
REQ-033 During and after reset: cpu_busrq_n=1, dma_ack=0, dma_owner=0, mem_we=0, arb_err=0, dma_rdata=00.
REQ-034 Reset mid-ACCESS SHALL abort the write with no ack; bus returns to CPU.

Configuration
REQ-035 Macro ARB_TIMEOUT_EN defined: in REQ, a counter SHALL run; TIMEOUT_CYCLES without busak_n=0 -> arb_err pulse, -> GAP, dma_req left pending.
REQ-036 ARB_TIMEOUT_EN undefined: REQ SHALL wait indefinitely; arb_err tied 0; no counter logic.

Verification
REQ-037 SHALL cover: reset, CPU program running; busak_n never asserted -> no DMA activity, CPU read/write of b5a8 via memory port correct.
REQ-038 SHALL cover: DMA write 0xA6 to b5a8 with CPU halted in busak -> busrq_n low, ack 2 cycles after accept, mem[b5a8]=A6, busrq_n high after dma_req drops.
REQ-039 SHALL cover: 20 back-to-back DMA reads, MAX_BURST=16 -> 16 acks, release, 4-cycle gap, re-request, 4 more acks.
REQ-040 SHALL cover: DMA then CPU executes FD CB 11 E7 from 0000 with IY=b597, mem[b5a8]=A6 -> mem[b5a8]=B6, A=B6, PC=0004.
REQ-041 SHALL cover: ARB_TIMEOUT_EN, busak_n held 1 -> arb_err pulse at cycle 255 of REQ, state GAP then re-request.
REQ-042 SHALL cover: reset_n low mid-ACCESS write -> no ack, mem unchanged, busrq_n=1 asynchronously.
